sub_serial: RTL and testbench

SUB_SERIAL -- requirements
Module: sub_serial

---
 rtl/sub_serial.sv | 142 ++++++++++++++
 tb/tb_sub_serial.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sub_serial.sv
// Bit-serial subtractor: one difference bit per clock, LSB first, valid/ready on both sides.
// Optional signed-overflow flag compiled in with `define SUB_SERIAL_OVF_EN.
module sub_serial #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_num_a,
   input  logic [WIDTH-1:0] i_num_b,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_res,
   output logic             o_brw,
   output logic             o_ovf
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nx;

   logic [WIDTH-1:0] sh_a;
   logic [WIDTH-1:0] sh_b;
   logic [WIDTH-1:0] acc;
   logic [CW-1:0]    cnt;
   logic             br;

   logic             a_bit;
   logic             b_bit;
   logic             d_bit;
   logic             br_nx;
   logic             last_bit;
   logic             accept;
   logic [WIDTH-1:0] res_nx;

   assign accept   = (state == IDLE) && i_valid;
   assign last_bit = (cnt == CW'(WIDTH - 1));

   // Per-bit difference and borrow from the current operand LSBs
   always_comb begin
      a_bit  = sh_a[0];
      b_bit  = sh_b[0];
      d_bit  = a_bit ^ b_bit ^ br;
      br_nx  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
      res_nx = acc | (WIDTH'(d_bit) << cnt);
   end

   // State register
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (i_valid)  state_nx = BUSY;
         BUSY: if (last_bit) state_nx = DONE;
         DONE: if (i_ready)  state_nx = IDLE;
         default:            state_nx = IDLE;
      endcase
   end

   // Handshake outputs decoded from state
   always_comb begin
      o_ready = 1'b0;
      o_valid = 1'b0;
      unique case (state)
         IDLE:    o_ready = 1'b1;
         DONE:    o_valid = 1'b1;
         default: ;
      endcase
   end

   // Operand shifters, borrow, bit counter and partial result
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         sh_a <= '0;
         sh_b <= '0;
         acc  <= '0;
         cnt  <= '0;
         br   <= 1'b0;
      end else if (accept) begin
         sh_a <= i_num_a;
         sh_b <= i_num_b;
         acc  <= '0;
         cnt  <= '0;
         br   <= 1'b0;
      end else if (state == BUSY) begin
         sh_a <= sh_a >> 1;
         sh_b <= sh_b >> 1;
         acc  <= res_nx;
         cnt  <= cnt + CW'(1);
         br   <= br_nx;
      end
   end

   // Published result, refreshed only as the last bit completes
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_res <= '0;
         o_brw <= 1'b0;
      end else if (state == BUSY && last_bit) begin
         o_res <= res_nx;
         o_brw <= br_nx;
      end
   end

`ifdef SUB_SERIAL_OVF_EN
   logic a_msb;
   logic b_msb;

   // Capture operand signs at accept, flag overflow with the final bit
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         a_msb <= 1'b0;
         b_msb <= 1'b0;
         o_ovf <= 1'b0;
      end else if (accept) begin
         a_msb <= i_num_a[WIDTH-1];
         b_msb <= i_num_b[WIDTH-1];
      end else if (state == BUSY && last_bit) begin
         o_ovf <= (a_msb != b_msb) && (d_bit != a_msb);
      end
   end
`else
   assign o_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_sub_serial.sv
// Randomized scoreboard bench for sub_serial.
// Reference model uses plain integer subtraction.
module tb_sub_serial;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         i_valid;
   logic         o_ready;
   logic [W-1:0] num_a;
   logic [W-1:0] num_b;
   logic         o_valid;
   logic         i_ready;
   logic [W-1:0] o_res;
   logic         o_brw;
   logic         o_ovf;

   sub_serial #(.WIDTH(W)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_num_a (num_a),
      .i_num_b (num_b),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_res   (o_res),
      .o_brw   (o_brw),
      .o_ovf   (o_ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] res;
      logic         brw;
      logic         ovf;
      int           acc;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endfunction

   function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, int acc_cyc);
      exp_t e;
      int   diff;
      int   sa;
      int   sb;
      int   sd;
      diff  = int'(a) - int'(b);
      e.res = diff[W-1:0];
      e.brw = (a < b);
      sa    = (int'(a) >= (1 << (W - 1))) ? int'(a) - (1 << W) : int'(a);
      sb    = (int'(b) >= (1 << (W - 1))) ? int'(b) - (1 << W) : int'(b);
      sd    = sa - sb;
`ifdef SUB_SERIAL_OVF_EN
      e.ovf = (sd > (1 << (W - 1)) - 1) || (sd < -(1 << (W - 1)));
`else
      e.ovf = 1'b0;
`endif
      e.acc = acc_cyc;
      return e;
   endfunction

   exp_t cur;
   bit   active = 0;

   // Monitor: pop on each new result, then check it every cycle it is held
   always @(negedge clk) begin
      if (!rst_n || !o_valid) begin
         active = 0;
      end else begin
         if (!active) begin
            if (q.size() == 0) begin
               chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
               cur = q.pop_front();
               chk("latency", cyc, cur.acc + W);
            end
            active = 1;
         end
         chk("res", {24'd0, o_res}, {24'd0, cur.res});
         chk("brw", {31'd0, o_brw}, {31'd0, cur.brw});
         chk("ovf", {31'd0, o_ovf}, {31'd0, cur.ovf});
      end
   end

   task automatic wait_ready();
      int t = 0;
      @(negedge clk);
      while (!o_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!o_ready) chk("ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic send(logic [W-1:0] a, logic [W-1:0] b, int bp, bit hold_iv);
      int t = 0;
      wait_ready();
      i_valid = 1'b1;
      num_a   = a;
      num_b   = b;
      @(posedge clk);
      #1;
      q.push_back(model(a, b, cyc));
      if (hold_iv) begin
         num_a = 8'hFF;
         num_b = 8'h01;
      end else begin
         i_valid = 1'b0;
         num_a   = W'($urandom);
         num_b   = W'($urandom);
      end
      while (!o_valid && t < 4 * W) begin
         @(negedge clk);
         if (!o_valid) chk("busy_ready", {31'd0, o_ready}, 32'd0);
         t++;
      end
      if (!o_valid) chk("valid_timeout", 32'd0, 32'd1);
      i_valid = 1'b0;
      repeat (bp) @(negedge clk);
      i_ready = 1'b1;
      @(posedge clk);
      #1;
      i_ready = 1'b0;
      chk("idle_ready", {31'd0, o_ready}, 32'd1);
      chk("idle_valid", {31'd0, o_valid}, 32'd0);
   endtask

   task automatic abort_test(bit in_done);
      int t = 0;
      wait_ready();
      i_valid = 1'b1;
      num_a   = 8'h05;
      num_b   = 8'h03;
      @(posedge clk);
      #1;
      q.push_back(model(8'h05, 8'h03, cyc));
      i_valid = 1'b0;
      if (in_done) begin
         while (!o_valid && t < 4 * W) begin
            @(negedge clk);
            t++;
         end
         if (!o_valid) chk("abort_valid_timeout", 32'd0, 32'd1);
         i_ready = 1'b1;
      end else begin
         repeat (3) @(posedge clk);
         #1;
      end
      rst_n   = 1'b0;
      i_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_ready", {31'd0, o_ready}, 32'd1);
      chk("rst_valid", {31'd0, o_valid}, 32'd0);
      chk("rst_res", {24'd0, o_res}, 32'd0);
      chk("rst_brw", {31'd0, o_brw}, 32'd0);
      chk("rst_ovf", {31'd0, o_ovf}, 32'd0);
      q.delete();
      rst_n   = 1'b1;
      i_valid = 1'b0;
      i_ready = 1'b0;
      repeat (2 * W) begin
         @(negedge clk);
         chk("abort_no_valid", {31'd0, o_valid}, 32'd0);
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      i_valid = 1'b0;
      i_ready = 1'b0;
      num_a   = '0;
      num_b   = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ready", {31'd0, o_ready}, 32'd1);
      chk("reset_valid", {31'd0, o_valid}, 32'd0);
      chk("reset_res", {24'd0, o_res}, 32'd0);
      chk("reset_brw", {31'd0, o_brw}, 32'd0);
      chk("reset_ovf", {31'd0, o_ovf}, 32'd0);
      rst_n = 1'b1;

      send(8'h05, 8'h03, 5, 1'b0);
      send(8'h03, 8'h05, 0, 1'b0);
      send(8'h00, 8'h00, 1, 1'b0);
      send(8'h80, 8'h01, 0, 1'b0);
      send(8'h7F, 8'hFF, 0, 1'b0);
      send(8'hFF, 8'hFF, 2, 1'b0);
      send(8'h05, 8'h03, 2, 1'b1);
      abort_test(1'b0);
      abort_test(1'b1);
      send(8'h05, 8'h03, 0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         send(W'($urandom), W'($urandom), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)));
      end

      repeat (3) @(negedge clk);
      chk("queue_empty", q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
